// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Write-back arbiter for the 32x32 register file write port. Merges the
// single-cycle ALU result stream with load results, which are buffered in a
// 2-entry FIFO. A starvation counter forces a pending load to win after the
// FIFO has been passed over STARVE_MAX consecutive cycles.
//
// Ports:
//   reloj_cucu          clock, rising edge
//   reset               asynchronous active-low reset
//   alu_valid/alu_ready ALU result handshake (alu_ready combinational)
//   alu_addr/alu_data   ALU destination register and result
//   mem_valid/mem_ready load result handshake (mem_ready from registered state)
//   mem_addr/mem_data   load destination register and data
//   r_write             registered register-file write enable
//   rd_addr/rd_w_data   registered register-file write address and data
//   fifo_count          load FIFO occupancy, 0..2
module regfile_wb_arbiter #(
    parameter int ADDR       = 5,
    parameter int BUS_W      = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic             reloj_cucu,
    input  logic             reset,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [ADDR-1:0]  alu_addr,
    input  logic [BUS_W-1:0] alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [ADDR-1:0]  mem_addr,
    input  logic [BUS_W-1:0] mem_data,
    output logic             r_write,
    output logic [ADDR-1:0]  rd_addr,
    output logic [BUS_W-1:0] rd_w_data,
    output logic [1:0]       fifo_count
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [ADDR-1:0]  fifo_addr [2];
    logic [BUS_W-1:0] fifo_data [2];
    logic             rd_ptr;
    logic [1:0]       count;
    logic [3:0]       starve_cnt;

    logic             fifo_empty;
    logic             grant_mem;
    logic             push;
    logic             wr_ptr;
    logic             win_valid;
    logic [ADDR-1:0]  win_addr;
    logic [BUS_W-1:0] win_data;

    assign fifo_empty = (count == 2'd0);
    assign mem_ready  = (count != 2'd2);
    assign push       = mem_valid & mem_ready;
    // Tail slot: with 0 or 1 entries the free slot is head + count.
    assign wr_ptr     = rd_ptr ^ count[0];
    assign grant_mem  = ~fifo_empty & (~alu_valid | (starve_cnt == STARVE_LIM));
    assign alu_ready  = ~grant_mem;
    assign fifo_count = count;

    assign win_valid  = grant_mem | alu_valid;
    assign win_addr   = grant_mem ? fifo_addr[rd_ptr] : alu_addr;
    assign win_data   = grant_mem ? fifo_data[rd_ptr] : alu_data;

    always_ff @(posedge reloj_cucu or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= mem_addr;
                fifo_data[wr_ptr] <= mem_data;
            end
            if (grant_mem) begin
                rd_ptr <= ~rd_ptr;
            end
            // push only happens when not full, pop only when not empty
            case ({push, grant_mem})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge reloj_cucu or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (fifo_empty || grant_mem) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Writes to register 0 are consumed without touching the write port.
    always_ff @(posedge reloj_cucu or negedge reset) begin
        if (!reset) begin
            r_write   <= 1'b0;
            rd_addr   <= '0;
            rd_w_data <= '0;
        end else if (win_valid && (win_addr != '0)) begin
            r_write   <= 1'b1;
            rd_addr   <= win_addr;
            rd_w_data <= win_data;
        end else begin
            r_write   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter. A queue-based reference model tracks
// the pending loads and the expected write port; a compare process checks every
// DUT output against it on each falling edge, and the directed sequences add
// literal expectations for the key cycles.
module tb_regfile_wb_arbiter;

    localparam int SMAX = 3;

    logic        reloj_cucu = 1'b0;
    logic        reset      = 1'b0;
    logic        alu_valid  = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_addr   = '0;
    logic [31:0] alu_data   = '0;
    logic        mem_valid  = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_addr   = '0;
    logic [31:0] mem_data   = '0;
    logic        r_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_w_data;
    logic [1:0]  fifo_count;

    int tests = 0;
    int fails = 0;

    regfile_wb_arbiter #(.ADDR(5), .BUS_W(32), .STARVE_MAX(SMAX)) dut (
        .reloj_cucu(reloj_cucu), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .r_write(r_write), .rd_addr(rd_addr), .rd_w_data(rd_w_data),
        .fifo_count(fifo_count)
    );

    always #5 reloj_cucu = ~reloj_cucu;

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    int          m_starve  = 0;
    logic        m_wr      = 1'b0;
    logic [4:0]  m_addr    = '0;
    logic [31:0] m_data    = '0;

    function automatic bit m_grant_mem();
        return (mq.size() != 0) && (!alu_valid || m_starve == SMAX);
    endfunction

    always @(posedge reloj_cucu or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_starve = 0;
            m_wr     = 1'b0;
            m_addr   = '0;
            m_data   = '0;
        end else begin
            bit   g, pushing, have;
            ent_t w;
            int   sz;
            sz      = mq.size();
            g       = m_grant_mem();
            pushing = mem_valid && (sz < 2);
            have    = 1'b0;
            w.a = '0;
            w.d = '0;
            if (g) begin
                w = mq.pop_front();
                have = 1'b1;
            end else if (alu_valid) begin
                w.a = alu_addr;
                w.d = alu_data;
                have = 1'b1;
            end
            if (pushing) begin
                ent_t e;
                e.a = mem_addr;
                e.d = mem_data;
                mq.push_back(e);
            end
            if (g || sz == 0) m_starve = 0;
            else if (m_starve < SMAX) m_starve = m_starve + 1;
            if (have && w.a != 0) begin
                m_wr   = 1'b1;
                m_addr = w.a;
                m_data = w.d;
            end else begin
                m_wr = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge reloj_cucu) begin
        chk("model r_write",    32'(r_write),    32'(m_wr));
        chk("model rd_addr",    32'(rd_addr),    32'(m_addr));
        chk("model rd_w_data",  rd_w_data,       m_data);
        chk("model fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("model mem_ready",  32'(mem_ready),  32'(mq.size() != 2));
        chk("model alu_ready",  32'(alu_ready),  32'(!m_grant_mem()));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge reloj_cucu);
        #1;
    endtask

    task automatic idle(input int n);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge reloj_cucu);
        #1;
        chk("reset r_write",    32'(r_write),    32'd0);
        chk("reset rd_addr",    32'(rd_addr),    32'd0);
        chk("reset fifo_count", 32'(fifo_count), 32'd0);
        chk("reset mem_ready",  32'(mem_ready),  32'd1);
        chk("reset alu_ready",  32'(alu_ready),  32'd1);
        reset = 1'b1;
        tick();

        // ALU only
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        #1 chk("alu ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("alu r_write",   32'(r_write), 32'd1);
        chk("alu rd_addr",   32'(rd_addr), 32'd5);
        chk("alu rd_w_data", rd_w_data,    32'hDEADBEEF);
        tick();
        chk("alu one-shot", 32'(r_write), 32'd0);

        // load only
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h1234;
        #1 chk("load mem_ready", 32'(mem_ready), 32'd1);
        tick();
        mem_valid = 1'b0;
        chk("load count N+1",   32'(fifo_count), 32'd1);
        chk("load no bypass",   32'(r_write),    32'd0);
        tick();
        chk("load r_write N+2", 32'(r_write),    32'd1);
        chk("load rd_addr N+2", 32'(rd_addr),    32'd7);
        chk("load data N+2",    rd_w_data,       32'h1234);
        chk("load count N+2",   32'(fifo_count), 32'd0);
        idle(2);

        // FIFO full under continuous ALU traffic
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h0000_1111;
        mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'h0A0A_0010;
        tick();
        mem_addr = 5'd11; mem_data = 32'h0B0B_0011; alu_data = 32'h0000_2222;
        tick();
        mem_addr = 5'd12; mem_data = 32'h0C0C_0012; alu_data = 32'h0000_3333;
        chk("full mem_ready", 32'(mem_ready),  32'd0);
        chk("full count",     32'(fifo_count), 32'd2);
        n = 0;
        while (!mem_ready && n < 20) begin
            tick();
            alu_data = alu_data + 32'd1;
            n++;
        end
        chk("full wait cycles", 32'(n), 32'd3);
        tick();
        mem_valid = 1'b0;
        idle(8);
        chk("full drained", 32'(fifo_count), 32'd0);

        // starvation
        alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'hA5A5_0002;
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h0000_0099;
        tick();
        mem_valid = 1'b0;
        for (int k = 0; k < SMAX; k++) begin
            chk("starve alu wins", 32'(alu_ready), 32'd1);
            tick();
            chk("starve alu write", 32'(rd_addr), 32'd2);
        end
        chk("starve grant alu_ready", 32'(alu_ready), 32'd0);
        tick();
        chk("starve load r_write", 32'(r_write), 32'd1);
        chk("starve load rd_addr", 32'(rd_addr), 32'd9);
        chk("starve load data",    rd_w_data,    32'h0000_0099);
        tick();
        alu_valid = 1'b0;
        chk("starve alu resumes", 32'(rd_addr), 32'd2);
        tick();

        // address 0
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
        #1 chk("zero alu accepted", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h5555_AAAA;
        #1 chk("zero mem accepted", 32'(mem_ready), 32'd1);
        tick();
        mem_valid = 1'b0;
        chk("zero load queued", 32'(fifo_count), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("zero no write", 32'(r_write), 32'd0);
            tick();
        end
        chk("zero rd_addr held",   32'(rd_addr),    32'd2);
        chk("zero rd_w_data held", rd_w_data,       32'hA5A5_0002);
        chk("zero fifo drained",   32'(fifo_count), 32'd0);

        // async reset with queued loads
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h3333_0003;
        mem_valid = 1'b1; mem_addr = 5'd20; mem_data = 32'h2020_2020;
        tick();
        mem_addr = 5'd21; mem_data = 32'h2121_2121;
        tick();
        mem_valid = 1'b0;
        chk("pre-reset count", 32'(fifo_count), 32'd2);
        #1 reset = 1'b0;
        #1;
        chk("rst fifo_count", 32'(fifo_count), 32'd0);
        chk("rst r_write",    32'(r_write),    32'd0);
        chk("rst rd_addr",    32'(rd_addr),    32'd0);
        chk("rst rd_w_data",  rd_w_data,       32'd0);
        chk("rst mem_ready",  32'(mem_ready),  32'd1);
        alu_valid = 1'b0;
        #1 reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post-rst no write", 32'(r_write),    32'd0);
            chk("post-rst empty",    32'(fifo_count), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
